// File: rtl/dbus_pkg.sv
// Shared constants for the CPU data-bus fabric: region decode width, IO page
// register offsets and the value returned for reads of unmapped space.
package dbus_pkg;

    localparam int unsigned DBUS_REGION_W = 2;
    localparam int unsigned IO_OFF_W      = 2;
    localparam int unsigned CNT_W         = 32;

    typedef enum logic [IO_OFF_W-1:0] {
        IO_LED    = 2'd0,
        IO_CYCLES = 2'd1,
        IO_WRITES = 2'd2,
        IO_ERR    = 2'd3
    } io_off_e;

    // Every bit of an unmapped read returns this value.
    localparam logic UNMAPPED_RBIT = 1'b0;

endpackage

// File: rtl/dbus_io_regs.sv
// Internal IO page of the data-bus fabric: LED register, cycle counter,
// write counter, sticky unmapped-access flag and the registered read port.
module dbus_io_regs
    import dbus_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LED_W  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_io_wen,
    input  logic [IO_OFF_W-1:0] i_off,
    input  logic [LED_W-1:0]    i_led_wdata,
    input  logic                i_w1c_bit,
    input  logic                i_count_wr,
    input  logic                i_unmapped,
    output logic [DATA_W-1:0]   o_rdata,
    output logic [LED_W-1:0]    o_led,
    output logic                o_err
);

    logic [LED_W-1:0]  r_led;
    logic [CNT_W-1:0]  r_cycles;
    logic [CNT_W-1:0]  r_writes;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rd_val;
    io_off_e           w_off;

    assign w_off = io_off_e'(i_off);

    // Read value selected from the pre-update register contents.
    always_comb begin
        w_rd_val = '0;
        case (w_off)
            IO_LED:    w_rd_val = DATA_W'(r_led);
            IO_CYCLES: w_rd_val = DATA_W'(r_cycles);
            IO_WRITES: w_rd_val = DATA_W'(r_writes);
            IO_ERR:    w_rd_val = DATA_W'(r_err);
            default:   w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led    <= '0;
            r_cycles <= '0;
            r_writes <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_cycles <= r_cycles + CNT_W'(1);
            r_rdata  <= w_rd_val;
            if (i_count_wr) begin
                r_writes <= r_writes + CNT_W'(1);
            end
            if (i_io_wen && (w_off == IO_LED)) begin
                r_led <= i_led_wdata;
            end
            // A new unmapped access takes priority over a clear.
            if (i_unmapped) begin
                r_err <= 1'b1;
            end else if (i_io_wen && (w_off == IO_ERR) && i_w1c_bit) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_led   = r_led;
    assign o_err   = r_err;

endmodule

// File: rtl/dbus_fabric.sv
// CPU data-bus interconnect: region decode, one-hot slave write enables,
// single-cycle read return from slaves or the internal IO page.
module dbus_fabric
    import dbus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REGION_W = DBUS_REGION_W,
    parameter int unsigned N_SLV    = 2,
    parameter int unsigned LED_W    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          dbus_addr,
    input  logic [DATA_W-1:0]          dbus_write,
    input  logic                       dbus_wen,
    output logic [DATA_W-1:0]          dbus_read,
    output logic [ADDR_W-REGION_W-1:0] slv_addr,
    output logic [DATA_W-1:0]          slv_wdata,
    output logic [N_SLV-1:0]           slv_wen,
    input  logic [N_SLV*DATA_W-1:0]    slv_rdata,
    output logic [LED_W-1:0]           led,
    output logic                       err
);

    localparam logic [REGION_W-1:0] IO_REGION = REGION_W'(N_SLV);

    if (LED_W > DATA_W) begin : g_bad_led_w
        $error("dbus_fabric: LED_W must not exceed DATA_W");
    end
    if (N_SLV > (2**REGION_W) - 1) begin : g_bad_n_slv
        $error("dbus_fabric: N_SLV leaves no region for the IO page");
    end

    logic [REGION_W-1:0] w_region;
    logic                w_is_io;
    logic                w_unmapped;
    logic                w_count_wr;
    logic [REGION_W-1:0] r_rd_sel;
    logic [DATA_W-1:0]   w_io_rdata;

    assign w_region   = dbus_addr[ADDR_W-1 -: REGION_W];
    assign w_is_io    = (w_region == IO_REGION);
    assign w_unmapped = (w_region > IO_REGION);
    assign w_count_wr = dbus_wen & ~w_unmapped;

    assign slv_addr  = dbus_addr[ADDR_W-REGION_W-1:0];
    assign slv_wdata = dbus_write;

    always_comb begin
        slv_wen = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            slv_wen[k] = dbus_wen & ~rst & (w_region == REGION_W'(k));
        end
    end

    // Reset parks the read selector on the IO page, whose read register is zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_sel <= IO_REGION;
        end else begin
            r_rd_sel <= w_region;
        end
    end

    dbus_io_regs #(
        .DATA_W (DATA_W),
        .LED_W  (LED_W)
    ) u_io (
        .clk         (clk),
        .rst         (rst),
        .i_io_wen    (dbus_wen & w_is_io),
        .i_off       (dbus_addr[3:2]),
        .i_led_wdata (dbus_write[LED_W-1:0]),
        .i_w1c_bit   (dbus_write[0]),
        .i_count_wr  (w_count_wr),
        .i_unmapped  (w_unmapped),
        .o_rdata     (w_io_rdata),
        .o_led       (led),
        .o_err       (err)
    );

    always_comb begin
        dbus_read = {DATA_W{UNMAPPED_RBIT}};
        if (r_rd_sel == IO_REGION) begin
            dbus_read = w_io_rdata;
        end else begin
            for (int unsigned k = 0; k < N_SLV; k++) begin
                if (r_rd_sel == REGION_W'(k)) begin
                    dbus_read = slv_rdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_fabric.sv
// Directed bench for dbus_fabric with two registered-read RAM slave models.
module tb_dbus_fabric;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REGION_W = 2;
    localparam int unsigned N_SLV    = 2;
    localparam int unsigned LED_W    = 1;

    localparam logic [31:0] VAL_A = 32'hAAAA5555;
    localparam logic [31:0] VAL_B = 32'h0BADBEEF;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [ADDR_W-1:0]          dbus_addr;
    logic [DATA_W-1:0]          dbus_write;
    logic                       dbus_wen;
    logic [DATA_W-1:0]          dbus_read;
    logic [ADDR_W-REGION_W-1:0] slv_addr;
    logic [DATA_W-1:0]          slv_wdata;
    logic [N_SLV-1:0]           slv_wen;
    logic [N_SLV*DATA_W-1:0]    slv_rdata;
    logic [LED_W-1:0]           led;
    logic                       err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    always #5 clk = ~clk;

    dbus_fabric #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .REGION_W (REGION_W),
        .N_SLV    (N_SLV),
        .LED_W    (LED_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dbus_addr  (dbus_addr),
        .dbus_write (dbus_write),
        .dbus_wen   (dbus_wen),
        .dbus_read  (dbus_read),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_wen    (slv_wen),
        .slv_rdata  (slv_rdata),
        .led        (led),
        .err        (err)
    );

    // Slave RAMs: registered read of old contents, write on own enable.
    always @(posedge clk) begin
        slv_rdata[31:0]  <= mem0[slv_addr[5:2]];
        slv_rdata[63:32] <= mem1[slv_addr[5:2]];
        if (slv_wen[0]) mem0[slv_addr[5:2]] <= slv_wdata;
        if (slv_wen[1]) mem1[slv_addr[5:2]] <= slv_wdata;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] a, input logic w, input logic [31:0] d);
        dbus_addr  = a;
        dbus_wen   = w;
        dbus_write = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(16'h0000, 1'b1, 32'h0);
        step();
        step();
        checks++; if (slv_wen !== 2'b00) begin failures++; $display("FAIL reset_slv_wen: got %b expected 00", slv_wen); end
        checks++; if (dbus_read !== 32'h0) begin failures++; $display("FAIL reset_dbus_read: got %h expected 00000000", dbus_read); end
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL reset_led: got %b expected 0", led); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        dbus_wen = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (dbus_read !== 32'h0) begin failures++; $display("FAIL reset_release_read: got %h expected 00000000", dbus_read); end
        step();
    endtask

    task automatic test_io_led();
        drive(16'h8000, 1'b1, 32'h1);
        #1;
        checks++; if (slv_wen !== 2'b00) begin failures++; $display("FAIL io_slv_wen: got %b expected 00", slv_wen); end
        step();
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL io_led_set: got %b expected 1", led); end
        drive(16'h8000, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h1) begin failures++; $display("FAIL io_led_read: got %h expected 00000001", dbus_read); end
        drive(16'h8008, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h1) begin failures++; $display("FAIL io_writes_1: got %h expected 00000001", dbus_read); end
        drive(16'h8004, 1'b1, 32'hFFFF);
        step();
        drive(16'h8008, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h2) begin failures++; $display("FAIL io_writes_ro: got %h expected 00000002", dbus_read); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL io_ro_no_err: got %b expected 0", err); end
    endtask

    task automatic test_write_read();
        drive(16'h0010, 1'b1, 32'h12345678);
        #1;
        checks++; if (slv_wen !== 2'b01) begin failures++; $display("FAIL wr_slv_wen: got %b expected 01", slv_wen); end
        checks++; if (slv_addr !== 14'h0010) begin failures++; $display("FAIL wr_slv_addr: got %h expected 0010", slv_addr); end
        checks++; if (slv_wdata !== 32'h12345678) begin failures++; $display("FAIL wr_slv_wdata: got %h expected 12345678", slv_wdata); end
        step();
        drive(16'h0010, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h12345678) begin failures++; $display("FAIL wr_readback: got %h expected 12345678", dbus_read); end
    endtask

    task automatic test_back_to_back();
        drive(16'h4000, 1'b1, VAL_A);
        #1;
        checks++; if (slv_wen !== 2'b10) begin failures++; $display("FAIL b2b_slv_wen: got %b expected 10", slv_wen); end
        step();
        drive(16'h0000, 1'b1, VAL_B);
        step();
        drive(16'h4000, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== VAL_A) begin failures++; $display("FAIL b2b_first: got %h expected %h", dbus_read, VAL_A); end
        drive(16'h0000, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== VAL_B) begin failures++; $display("FAIL b2b_second: got %h expected %h", dbus_read, VAL_B); end
        drive(16'h8008, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h5) begin failures++; $display("FAIL b2b_writes: got %h expected 00000005", dbus_read); end
    endtask

    task automatic test_unmapped();
        drive(16'hC000, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h0) begin failures++; $display("FAIL unm_read: got %h expected 00000000", dbus_read); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL unm_err_set: got %b expected 1", err); end
        drive(16'hC00C, 1'b1, 32'h1);
        #1;
        checks++; if (slv_wen !== 2'b00) begin failures++; $display("FAIL unm_slv_wen: got %b expected 00", slv_wen); end
        step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL unm_err_hold: got %b expected 1", err); end
        drive(16'h8008, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h5) begin failures++; $display("FAIL unm_writes: got %h expected 00000005", dbus_read); end
        drive(16'h800C, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== 32'h1) begin failures++; $display("FAIL unm_err_read: got %h expected 00000001", dbus_read); end
        drive(16'h800C, 1'b1, 32'h1);
        step();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL unm_w1c: got %b expected 0", err); end
        drive(16'h800C, 1'b0, 32'h0);
    endtask

    task automatic test_cycles_wrap();
        drive(16'h8004, 1'b0, 32'h0);
        force dut.u_io.r_cycles = 32'hFFFFFFFE;
        #1;
        release dut.u_io.r_cycles;
        step();
        checks++; if (dbus_read !== 32'hFFFFFFFE) begin failures++; $display("FAIL cyc_pre: got %h expected FFFFFFFE", dbus_read); end
        step();
        checks++; if (dbus_read !== 32'hFFFFFFFF) begin failures++; $display("FAIL cyc_max: got %h expected FFFFFFFF", dbus_read); end
        step();
        checks++; if (dbus_read !== 32'h0) begin failures++; $display("FAIL cyc_wrap: got %h expected 00000000", dbus_read); end
        step();
        checks++; if (dbus_read !== 32'h1) begin failures++; $display("FAIL cyc_after: got %h expected 00000001", dbus_read); end
    endtask

    task automatic test_reset_mid();
        drive(16'hC000, 1'b0, 32'h0);
        step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rmid_err_pre: got %b expected 1", err); end
        drive(16'h4000, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dbus_read !== 32'h0) begin failures++; $display("FAIL rmid_read: got %h expected 00000000", dbus_read); end
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL rmid_led: got %b expected 0", led); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmid_err: got %b expected 0", err); end
        step();
        step();
        rst = 1'b0;
        drive(16'h8004, 1'b0, 32'h0);
        #1;
        checks++; if (dbus_read !== 32'h0) begin failures++; $display("FAIL rmid_release: got %h expected 00000000", dbus_read); end
        step();
        checks++; if (dbus_read !== 32'h0) begin failures++; $display("FAIL rmid_cyc0: got %h expected 00000000", dbus_read); end
        step();
        checks++; if (dbus_read !== 32'h1) begin failures++; $display("FAIL rmid_cyc1: got %h expected 00000001", dbus_read); end
        drive(16'h4000, 1'b0, 32'h0);
        step();
        checks++; if (dbus_read !== VAL_A) begin failures++; $display("FAIL rmid_slave_kept: got %h expected %h", dbus_read, VAL_A); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        rst = 1'b1;
        drive(16'h0000, 1'b0, 32'h0);
        test_reset();
        test_io_led();
        test_write_read();
        test_back_to_back();
        test_unmapped();
        test_cycles_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
